// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//   Single-clock minutes:seconds timekeeping core driven by tick enables.
//   Counts up (wrap or saturate at MIN_MAX:SEC_MAX) or down (expiring at 0:00),
//   supports manual field adjust at the 2 Hz rate and a lap-freeze register.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   tick_1hz     count-enable pulse
//   tick_2hz     adjust-enable pulse
//   clr          synchronous clear pulse
//   pause_toggle toggles the run state
//   lap          captures / releases the lap value
//   adjust       level, manual adjust mode
//   select       level, adjust field: 0 = minutes, 1 = seconds
//   count_down   level, 1 = decrement, 0 = increment
//   minutes      displayed minutes (lap value while lap_active)
//   seconds      displayed seconds (lap value while lap_active)
//   running      run state
//   lap_active   display frozen on the captured lap value
//   expired      count-down reached 0:00
//   blink        adjust-mode blink phase
//
// Control interface: all control inputs are single-cycle pulses or levels in
// the clk domain; there is no handshake. Every input takes effect on the clk
// edge that samples it and is visible on the outputs right after that edge.
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59,
  parameter int MIN_W   = 6,
  parameter bit WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             clr,
  input  logic             pause_toggle,
  input  logic             lap,
  input  logic             adjust,
  input  logic             select,
  input  logic             count_down,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             running,
  output logic             lap_active,
  output logic             expired,
  output logic             blink
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);
  localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
  localparam logic [5:0]       SEC_TOP = 6'(SEC_MAX);

  logic [MIN_W-1:0] min_q, min_d, lap_min_q, lap_min_d;
  logic [5:0]       sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic             running_q, running_d;
  logic             lap_active_q, lap_active_d;
  logic             expired_q, expired_d;
  logic             blink_q, blink_d;
  logic             count_down_q;

  // Next-state logic. Priority: clr, then adjust, then normal counting.
  // The run/expired qualification of tick_1hz uses the pre-update values,
  // so a pause_toggle in the same cycle does not block that tick.
  always_comb begin
    min_d        = min_q;
    sec_d        = sec_q;
    lap_min_d    = lap_min_q;
    lap_sec_d    = lap_sec_q;
    lap_active_d = lap_active_q;
    expired_d    = expired_q;
    running_d    = pause_toggle ? ~running_q : running_q;
    blink_d      = adjust ? (blink_q ^ tick_2hz) : 1'b0;

    if (clr) begin
      min_d        = '0;
      sec_d        = '0;
      expired_d    = 1'b0;
      lap_active_d = 1'b0;
    end else if (adjust) begin
      lap_active_d = 1'b0;
      if (tick_2hz) begin
        expired_d = 1'b0;
        // Field wraps on its own; no carry between fields.
        if (select) begin
          sec_d = (sec_q == SEC_TOP) ? 6'd0 : sec_q + 6'd1;
        end else begin
          min_d = (min_q == MIN_TOP) ? '0 : min_q + MIN_ONE;
        end
      end
    end else begin
      // Lap capture takes the pre-update live value.
      if (lap) begin
        if (!lap_active_q) begin
          lap_min_d    = min_q;
          lap_sec_d    = sec_q;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end
      if (tick_1hz && running_q && !expired_q) begin
        if (!count_down) begin
          if (sec_q != SEC_TOP) begin
            sec_d = sec_q + 6'd1;
          end else if (min_q != MIN_TOP) begin
            sec_d = 6'd0;
            min_d = min_q + MIN_ONE;
          end else if (WRAP) begin
            sec_d = 6'd0;
            min_d = '0;
          end
        end else begin
          if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
          end else if (min_q != '0) begin
            sec_d = SEC_TOP;
            min_d = min_q - MIN_ONE;
          end else begin
            expired_d = 1'b1;
          end
        end
      end
    end

    // Leaving count-down mode releases an expired stopwatch.
    if (count_down_q && !count_down) begin
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q        <= '0;
      sec_q        <= '0;
      lap_min_q    <= '0;
      lap_sec_q    <= '0;
      running_q    <= 1'b1;
      lap_active_q <= 1'b0;
      expired_q    <= 1'b0;
      blink_q      <= 1'b0;
      count_down_q <= 1'b0;
    end else begin
      min_q        <= min_d;
      sec_q        <= sec_d;
      lap_min_q    <= lap_min_d;
      lap_sec_q    <= lap_sec_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      expired_q    <= expired_d;
      blink_q      <= blink_d;
      count_down_q <= count_down;
    end
  end

  // Display mux selects between two registered values only.
  assign minutes    = lap_active_q ? lap_min_q : min_q;
  assign seconds    = lap_active_q ? lap_sec_q : sec_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign expired    = expired_q;
  assign blink      = blink_q;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised single-clock minutes:seconds timekeeping core. It replaces the derived-clock counter with tick-enable inputs. It adds count-down mode with expiry, a lap-freeze register and a configurable range (wrap or saturate). It sits between the debouncers/tick generator and the seven-segment display driver. All control inputs are one-cycle pulses or levels in the clk domain.

Parameters:
MIN_MAX, 59, largest minutes value; must satisfy MIN_MAX < 2**MIN_W
SEC_MAX, 59, largest seconds value; must satisfy SEC_MAX < 64
MIN_W, 6, width of the minutes field
WRAP, 1, count-up at MIN_MAX:SEC_MAX: 1 = wrap to 0:00, 0 = saturate and hold

Ports:
clk  input  1  system clock (100 MHz)
reset_n  input  1  asynchronous active-low reset
tick_1hz  input  1  one-cycle count-enable pulse, 1 Hz
tick_2hz  input  1  one-cycle adjust-enable pulse, 2 Hz
clr  input  1  one-cycle synchronous clear pulse (debounced button)
pause_toggle  input  1  one-cycle pulse; toggles run state
lap  input  1  one-cycle pulse; captures or releases the lap value
adjust  input  1  level; 1 = manual adjust mode
select  input  1  level; adjust field select: 0 = minutes, 1 = seconds
count_down  input  1  level; 1 = decrement, 0 = increment
minutes  output  MIN_W  displayed minutes (lap value when lap_active)
seconds  output  6  displayed seconds (lap value when lap_active)
running  output  1  run state
lap_active  output  1  display frozen on the captured lap value
expired  output  1  count-down reached 0:00
blink  output  1  adjust-mode blink phase for the selected display field

Behaviour:
- Reset (reset_n=0, async): live and lap counters = 0:00; running=1; lap_active=0; expired=0; blink=0.
- All state is registered. Outputs change on the clk edge that samples a qualifying pulse (1-cycle latency). No combinational path from inputs to outputs except through the registers.
- Priority per cycle: clr > adjust > normal counting.
- clr: live = 0:00, expired=0, lap_active=0. running is unchanged. Any tick in the same cycle is ignored.
- Normal mode (adjust=0): on tick_1hz with running=1 and expired=0:
  - Count-up:
    - sec<SEC_MAX: sec+1.
    - sec==SEC_MAX and min<MIN_MAX: sec=0, min+1.
    - At MIN_MAX:SEC_MAX: WRAP=1 gives 0:00; WRAP=0 holds the value.
  - Count-down:
    - sec>0: sec-1.
    - sec==0 and min>0: sec=SEC_MAX, min-1.
    - At 0:00: no change, expired=1.
- expired holds until clr, an adjust step, or a count_down 1->0 transition. While expired=1, tick_1hz has no effect.
- Adjust mode (adjust=1):
  - tick_1hz is ignored.
  - On tick_2hz, the selected field increments by 1, wrapping at its own max to 0, with no carry into the other field. This applies in either count direction.
  - Each adjust step clears expired.
  - blink toggles on every tick_2hz while adjust=1; it is forced to 0 on the cycle adjust=0 is sampled.
- pause_toggle: running <= ~running. Accepted in any mode. A tick_1hz in the same cycle uses the pre-toggle running value.
- lap:
  - lap_active=0: capture live into lap regs and set lap_active=1. Live counting continues.
  - lap_active=1: set lap_active=0.
  - lap is ignored while adjust=1. Entering adjust forces lap_active=0.
  - A lap pulse coinciding with a tick captures the pre-update live value.
- minutes/seconds mux: lap regs when lap_active=1, else live regs.
- Illegal values are unreachable: all arithmetic compares against MIN_MAX/SEC_MAX, never relying on natural overflow.
- count_down changes take effect on the next tick. There is no state reset on a direction change other than clearing expired on 1->0.

Test Plan:
- Reset, 61 tick_1hz pulses, count_down=0 -> minutes=1, seconds=1, running=1, expired=0.
- Preload 59:59 via adjust, WRAP=1, one tick_1hz -> 0:00. Rebuild with WRAP=0, same stimulus -> holds 59:59.
- Adjust to 1:01, count_down=1, 61 ticks -> 0:00 and expired=0. Next tick -> expired=1; further ticks keep 0:00. Then clr -> expired=0.
- Adjust=1, select=1, seconds=58, three tick_2hz -> seconds 59, 0, 1 with minutes unchanged; blink toggles 3 times; tick_1hz in between has no effect.
- At 0:10, pulse lap -> display frozen at 0:10 while 5 ticks run; pulse lap again -> display 0:15, lap_active=0. lap and tick in the same cycle at 0:20 -> frozen display 0:20, live 0:21.
- pause_toggle and tick_1hz in the same cycle while running -> the count advances once, then running=0 and further ticks are ignored. reset_n asserted mid-count -> all outputs return to reset values immediately, without waiting for a clock edge.
